// File: rtl/player_pkg.sv
// Player geometry shared by the controller and the draw stage.
package player_pkg;

  localparam int POS_W         = 12;
  localparam int SCREEN_WIDTH  = 640;
  localparam int PLAYER_WIDTH  = 40;
  localparam int PLAYER_X_INIT = 20;
  localparam int PLAYER_X_MIN  = 0;
  localparam int PLAYER_X_MAX  = SCREEN_WIDTH - PLAYER_WIDTH;
  localparam int GROUND_Y      = 0;

endpackage

// File: rtl/state_pkg.sv
// Animation states of player 1, shared by the controller and the draw stage.
package state_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RIGHT1 = 3'd1,
    RIGHT2 = 3'd2,
    LEFT1  = 3'd3,
    LEFT2  = 3'd4
  } State;

endpackage

// File: rtl/player1_jump.sv
// Vertical jump physics: constant-gravity ballistic arc from ground, advanced once per enable.
module player1_jump
  import player_pkg::*;
#(
  parameter int JUMP_V0 = 12,
  parameter int GRAVITY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    jump,
  output logic signed [POS_W-1:0] y,
  output logic                    airborne
);

  localparam logic signed [7:0]       V0     = 8'(JUMP_V0);
  localparam logic signed [7:0]       G      = 8'(GRAVITY);
  localparam logic signed [POS_W-1:0] GROUND = POS_W'(GROUND_Y);

  logic signed [POS_W-1:0] y_q, y_d, y_next;
  logic signed [7:0]       vy_q, vy_d;
  logic                    air_q, air_d;

  always_comb begin
    y_d    = y_q;
    vy_d   = vy_q;
    air_d  = air_q;
    y_next = y_q + {{(POS_W-8){vy_q[7]}}, vy_q};
    if (en) begin
      if (!air_q) begin
        // Take-off tick only loads the velocity; y moves from the next tick.
        if (jump) begin
          air_d = 1'b1;
          vy_d  = -V0;
        end
      end else if (y_next >= GROUND) begin
        y_d   = GROUND;
        vy_d  = '0;
        air_d = 1'b0;
      end else begin
        y_d  = y_next;
        vy_d = vy_q + G;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= GROUND;
      vy_q  <= '0;
      air_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vy_q  <= vy_d;
      air_q <= air_d;
    end
  end

  assign y        = y_q;
  assign airborne = air_q;

endmodule

// File: rtl/player1_ctl.sv
// Player 1 controller: per-frame horizontal walk with clamping, walk animation FSM and jump.
module player1_ctl
  import state_pkg::*, player_pkg::*;
#(
  parameter int X_INIT      = PLAYER_X_INIT,
  parameter int X_MIN       = PLAYER_X_MIN,
  parameter int X_MAX       = PLAYER_X_MAX,
  parameter int STEP        = 4,
  parameter int ANIM_FRAMES = 8,
  parameter int JUMP_V0     = 12,
  parameter int GRAVITY     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vblnk,
  input  logic             left,
  input  logic             right,
  input  logic             jump,
  output logic [POS_W-1:0] xpos_player1,
  output logic [POS_W-1:0] ypos_player1,
  output State             state
);

  localparam int                AW        = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [AW-1:0]     ANIM_LAST = AW'(ANIM_FRAMES - 1);
  localparam logic [POS_W-1:0]  X_INIT_W  = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]  X_MIN_W   = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]  X_MAX_W   = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]  STEP_W    = POS_W'(STEP);

  logic                    vblnk_d_q;
  logic                    frame_tick;
  logic                    go_right, go_left;
  logic [POS_W-1:0]        x_q, x_d;
  State                    state_q, state_d;
  logic [AW-1:0]           anim_cnt_q, anim_cnt_d;
  logic signed [POS_W-1:0] y;
  logic                    airborne;

  assign frame_tick = vblnk & ~vblnk_d_q;
  assign go_right   = right & ~left;
  assign go_left    = left & ~right;

  // Bounds are tested before the add/subtract so x never wraps near either edge.
  always_comb begin
    x_d = x_q;
    if (frame_tick) begin
      if (go_right) begin
        x_d = (x_q >= X_MAX_W - STEP_W) ? X_MAX_W : x_q + STEP_W;
      end else if (go_left) begin
        x_d = (x_q < X_MIN_W + STEP_W) ? X_MIN_W : x_q - STEP_W;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    anim_cnt_d = anim_cnt_q;
    if (frame_tick) begin
      if (go_right) begin
        if (state_q == RIGHT1 || state_q == RIGHT2) begin
          if (anim_cnt_q == ANIM_LAST) begin
            state_d    = (state_q == RIGHT1) ? RIGHT2 : RIGHT1;
            anim_cnt_d = '0;
          end else begin
            anim_cnt_d = anim_cnt_q + AW'(1);
          end
        end else begin
          state_d    = RIGHT1;
          anim_cnt_d = '0;
        end
      end else if (go_left) begin
        if (state_q == LEFT1 || state_q == LEFT2) begin
          if (anim_cnt_q == ANIM_LAST) begin
            state_d    = (state_q == LEFT1) ? LEFT2 : LEFT1;
            anim_cnt_d = '0;
          end else begin
            anim_cnt_d = anim_cnt_q + AW'(1);
          end
        end else begin
          state_d    = LEFT1;
          anim_cnt_d = '0;
        end
      end else begin
        state_d    = IDLE;
        anim_cnt_d = '0;
      end
    end
  end

  // vblnk_d resets high so a vblnk already high at reset release is not a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d_q  <= 1'b1;
      x_q        <= X_INIT_W;
      state_q    <= IDLE;
      anim_cnt_q <= '0;
    end else begin
      vblnk_d_q  <= vblnk;
      x_q        <= x_d;
      state_q    <= state_d;
      anim_cnt_q <= anim_cnt_d;
    end
  end

  player1_jump #(
    .JUMP_V0 (JUMP_V0),
    .GRAVITY (GRAVITY)
  ) u_jump (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (frame_tick),
    .jump     (jump),
    .y        (y),
    .airborne (airborne)
  );

  assign xpos_player1 = x_q;
  assign ypos_player1 = y;
  assign state        = state_q;

endmodule

// File: tb/tb_player1_ctl.sv
// Randomised self-checking bench for player1_ctl against a closed-form frame-level model.
module tb_player1_ctl;
  import state_pkg::*;

  localparam int STEP = 4;
  localparam int XMAX = 600;
  localparam int XMIN = 0;
  localparam int ANIM = 8;
  localparam int V0   = 12;
  localparam int G    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vblnk = 1'b0;
  logic        left = 1'b0;
  logic        right = 1'b0;
  logic        jump = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  State        state;

  int tests_run = 0;
  int tests_failed = 0;

  int   m_x, m_y, m_k, m_n, m_dir;
  bit   m_air;
  State m_state;

  logic [11:0] t_x, t_y, e_x, e_y;
  State        t_s, e_s;

  always #5 clk = ~clk;

  player1_ctl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vblnk        (vblnk),
    .left         (left),
    .right        (right),
    .jump         (jump),
    .xpos_player1 (xpos),
    .ypos_player1 (ypos),
    .state        (state)
  );

  function automatic void model_reset();
    m_x = 20; m_y = 0; m_k = 0; m_n = 0; m_dir = 0; m_air = 0; m_state = IDLE;
  endfunction

  // Walk phase comes from how many consecutive frames the same direction was held;
  // height comes from the closed-form ballistic position after k airborne frames.
  function automatic void model_tick(bit l, bit r, bit j);
    int dir;
    dir = (r && !l) ? 1 : ((l && !r) ? 2 : 0);
    if (dir == 1) m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
    if (dir == 2) m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
    if (dir == 0) m_n = 0;
    else if (dir == m_dir) m_n++;
    else m_n = 1;
    m_dir = dir;
    if (dir == 0) m_state = IDLE;
    else if (((m_n - 1) / ANIM) % 2 == 0) m_state = (dir == 1) ? RIGHT1 : LEFT1;
    else m_state = (dir == 1) ? RIGHT2 : LEFT2;
    if (!m_air) begin
      if (j) begin
        m_air = 1;
        m_k = 0;
      end
    end else begin
      m_k++;
      m_y = G * m_k * (m_k - 1) / 2 - V0 * m_k;
      if (m_y >= 0) begin
        m_y = 0;
        m_air = 0;
      end
    end
  endfunction

  // One video frame: vblnk rises with the real request, then the inputs are scrambled
  // for the rest of the frame; outputs are captured just after the tick and at frame end.
  task automatic drive_frame(input bit l, input bit r, input bit j);
    @(negedge clk);
    left = l; right = r; jump = j; vblnk = 1'b1;
    @(posedge clk);
    model_tick(l, r, j);
    @(negedge clk);
    t_x = xpos; t_y = ypos; t_s = state;
    left = 1'($urandom); right = 1'($urandom); jump = 1'($urandom);
    repeat (2) @(negedge clk);
    vblnk = 1'b0;
    repeat (3) begin
      @(negedge clk);
      left = 1'($urandom); right = 1'($urandom); jump = 1'($urandom);
    end
    e_x = xpos; e_y = ypos; e_s = state;
  endtask

  task automatic test_reset();
    vblnk = 1'b1; right = 1'b1; jump = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    tests_run++;
    if (xpos !== 12'd20 || ypos !== 12'd0 || state !== IDLE) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: got x=%0d y=%0d %s, want x=20 y=0 IDLE",
               xpos, $signed(ypos), state.name());
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (xpos !== 12'd20 || ypos !== 12'd0 || state !== IDLE) begin
        tests_failed++;
        $display("[TB] FAIL reset_no_tick c%0d: got x=%0d y=%0d %s, want x=20 y=0 IDLE",
                 i, xpos, $signed(ypos), state.name());
      end
    end
    vblnk = 1'b0; right = 1'b0; jump = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_walk_right();
    for (int i = 1; i <= 20; i++) begin
      drive_frame(1'b0, 1'b1, 1'b0);
      tests_run++;
      if (t_x !== 12'(m_x) || t_y !== 12'(m_y) || t_s !== m_state ||
          e_x !== 12'(m_x) || e_y !== 12'(m_y) || e_s !== m_state) begin
        tests_failed++;
        $display("[TB] FAIL walk_right f%0d: got x=%0d y=%0d %s (end x=%0d %s), want x=%0d y=%0d %s",
                 i, t_x, $signed(t_y), t_s.name(), e_x, e_s.name(), m_x, m_y, m_state.name());
      end
    end
    tests_run++;
    if (xpos !== 12'd100) begin
      tests_failed++;
      $display("[TB] FAIL walk_right_final: got x=%0d, want x=100", xpos);
    end
  endtask

  task automatic test_left_clamp();
    for (int i = 1; i <= 30; i++) begin
      drive_frame(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (t_x !== 12'(m_x) || t_y !== 12'(m_y) || t_s !== m_state ||
          e_x !== 12'(m_x) || e_y !== 12'(m_y) || e_s !== m_state) begin
        tests_failed++;
        $display("[TB] FAIL left_clamp f%0d: got x=%0d %s (end x=%0d %s), want x=%0d %s",
                 i, t_x, t_s.name(), e_x, e_s.name(), m_x, m_state.name());
      end
    end
    tests_run++;
    if (xpos !== 12'd0) begin
      tests_failed++;
      $display("[TB] FAIL left_clamp_final: got x=%0d, want x=0", xpos);
    end
  endtask

  task automatic test_both_pressed();
    for (int i = 1; i <= 10; i++) begin
      drive_frame((i == 10), 1'b1, 1'b0);
      tests_run++;
      if (t_x !== 12'(m_x) || t_s !== m_state || e_x !== 12'(m_x) || e_s !== m_state) begin
        tests_failed++;
        $display("[TB] FAIL both_pressed f%0d: got x=%0d %s (end x=%0d %s), want x=%0d %s",
                 i, t_x, t_s.name(), e_x, e_s.name(), m_x, m_state.name());
      end
    end
    tests_run++;
    if (state !== IDLE || xpos !== 12'd36) begin
      tests_failed++;
      $display("[TB] FAIL both_pressed_final: got x=%0d %s, want x=36 IDLE", xpos, state.name());
    end
  endtask

  task automatic test_jump();
    int min_y = 0;
    for (int i = 0; i < 30; i++) begin
      drive_frame(1'b0, 1'b0, (i == 0 || i == 5 || i == 10 || i >= 26));
      if ($signed(t_y) < min_y) min_y = $signed(t_y);
      tests_run++;
      if (t_x !== 12'(m_x) || t_y !== 12'(m_y) || t_s !== m_state ||
          e_x !== 12'(m_x) || e_y !== 12'(m_y) || e_s !== m_state) begin
        tests_failed++;
        $display("[TB] FAIL jump f%0d: got y=%0d (end y=%0d) x=%0d %s, want y=%0d x=%0d %s",
                 i, $signed(t_y), $signed(e_y), t_x, t_s.name(), m_y, m_x, m_state.name());
      end
    end
    tests_run++;
    if (min_y != -78) begin
      tests_failed++;
      $display("[TB] FAIL jump_apex: got %0d, want -78", min_y);
    end
  endtask

  task automatic test_reset_mid_jump();
    drive_frame(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40 && m_y != -50; i++) drive_frame(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (ypos !== 12'(-50) || state === IDLE) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_pos: got y=%0d %s, want y=-50 walking", $signed(ypos), state.name());
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (xpos !== 12'd20 || ypos !== 12'd0 || state !== IDLE) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_jump: got x=%0d y=%0d %s, want x=20 y=0 IDLE",
               xpos, $signed(ypos), state.name());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      drive_frame(1'b0, 1'b0, (i == 0));
      tests_run++;
      if (t_x !== 12'(m_x) || t_y !== 12'(m_y) || t_s !== m_state ||
          e_x !== 12'(m_x) || e_y !== 12'(m_y) || e_s !== m_state) begin
        tests_failed++;
        $display("[TB] FAIL rejump_after_reset f%0d: got y=%0d x=%0d %s, want y=%0d x=%0d %s",
                 i, $signed(t_y), t_x, t_s.name(), m_y, m_x, m_state.name());
      end
    end
  endtask

  task automatic test_random();
    bit l, r, j;
    for (int i = 0; i < 150; i++) begin
      l = 1'($urandom);
      r = 1'($urandom);
      j = ($urandom_range(0, 3) == 0);
      drive_frame(l, r, j);
      tests_run++;
      if (t_x !== 12'(m_x) || t_y !== 12'(m_y) || t_s !== m_state ||
          e_x !== 12'(m_x) || e_y !== 12'(m_y) || e_s !== m_state) begin
        tests_failed++;
        $display("[TB] FAIL random f%0d l=%0d r=%0d j=%0d: got x=%0d y=%0d %s, want x=%0d y=%0d %s",
                 i, l, r, j, t_x, $signed(t_y), t_s.name(), m_x, m_y, m_state.name());
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_left_clamp();
    test_both_pressed();
    test_jump();
    test_reset_mid_jump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
